// File: rtl/addr_encode_pkg.sv
// Shared constants and state encoding for the 16-bit address/data link.
package addr_encode_pkg;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 14;
  localparam int WORD_W = ADDR_W + DATA_W;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUN     = 1'b1
  } state_t;

  // Address occupies the top bits so the receiver splits on a fixed boundary.
  function automatic logic [WORD_W-1:0] pack_word(input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] d);
    return {a, d};
  endfunction

endpackage

// File: rtl/addr_encode_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and registered full flag.
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int WORD_W = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_level, w_level_nxt;
  logic              r_full;
  logic              w_push, w_pop;

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign w_push = push && !r_full;
  assign w_pop  = pop && (r_level != '0);

  // Occupancy bookkeeping; the extra level bit separates full from empty.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + (AW+1)'(1);
      2'b01:   w_level_nxt = r_level - (AW+1)'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == (AW+1)'(DEPTH));
    end
  end

  // Storage needs no reset; validity is tracked by the level.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

  assign head  = r_mem[r_rd_ptr];
  assign full  = r_full;
  assign empty = (r_level == '0);
  assign level = r_level;

endmodule

// File: rtl/addr_encode.sv
// Transmit side of the address/data link: buffers words and launches one per
// forwarded-clock period, stopping the clock cleanly when disabled.
module addr_encode
  import addr_encode_pkg::*;
#(
  parameter int               DEPTH     = 16,
  parameter int               CLK_DIV   = 4,
  parameter logic [WORD_W-1:0] IDLE_WORD = '0,
  localparam int              LW        = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] data_out,
  output logic              clk_out,
  output logic              tx_active,
  output logic [LW-1:0]     fifo_level
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  state_t            r_state, w_state_nxt;
  logic [PW-1:0]     r_phase, w_phase_nxt;
  logic              r_clk_out, w_clk_nxt;
  logic [WORD_W-1:0] r_data_out, w_data_nxt;
  logic              w_launch, w_pop, w_push;
  logic              w_full, w_empty;
  logic [WORD_W-1:0] w_head;

  assign w_push = in_valid && !w_full;

  sync_fifo #(.DEPTH(DEPTH), .WORD_W(WORD_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (pack_word(addr_in, data_in)),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

  // State and phase registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_STOPPED;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // Next state: a running period always completes; enable is only sampled at its end.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    case (r_state)
      ST_STOPPED: begin
        w_phase_nxt = '0;
        if (enable) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (r_phase == PW'(CLK_DIV-1)) begin
          w_phase_nxt = '0;
          if (!enable) w_state_nxt = ST_STOPPED;
        end else begin
          w_phase_nxt = r_phase + PW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_STOPPED;
        w_phase_nxt = '0;
      end
    endcase
  end

  // Output decode: launch whenever the next cycle is phase 0 of a running period.
  always_comb begin
    w_launch   = (w_state_nxt == ST_RUN) && (w_phase_nxt == '0);
    w_pop      = w_launch && !w_empty;
    w_clk_nxt  = (w_state_nxt == ST_RUN) && (w_phase_nxt >= PW'(CLK_DIV/2));
    w_data_nxt = r_data_out;
    if (w_state_nxt != ST_RUN) w_data_nxt = '0;
    else if (w_launch)         w_data_nxt = w_empty ? IDLE_WORD : w_head;
  end

  // Registered link outputs so clk_out and data_out are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_out  <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_clk_out  <= w_clk_nxt;
      r_data_out <= w_data_nxt;
    end
  end

  assign clk_out   = r_clk_out;
  assign data_out  = r_data_out;
  assign tx_active = (r_state == ST_RUN);
  assign in_ready  = !w_full;

endmodule

// File: tb/tb_addr_encode.sv
// Bench for addr_encode: per-cycle table for clock shape, scoreboard for words.
module tb_addr_encode;

  logic        clk = 1'b0;
  logic        rst, enable, in_valid;
  logic [1:0]  addr_in;
  logic [13:0] data_in;
  logic        in_ready, clk_out, tx_active;
  logic [15:0] data_out;
  logic [4:0]  fifo_level;

  addr_encode #(.DEPTH(16), .CLK_DIV(4), .IDLE_WORD(16'h0000)) dut (
    .clk(clk), .rst(rst), .enable(enable), .addr_in(addr_in), .data_in(data_in),
    .in_valid(in_valid), .in_ready(in_ready), .data_out(data_out),
    .clk_out(clk_out), .tx_active(tx_active), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int          ncmp = 0, nerr = 0;
  logic [15:0] q[$];
  logic [15:0] last_word = '0;
  logic        prev_clk = 1'b0, prev_act = 1'b0;
  int          npop = 0;

  typedef struct {
    logic        en;
    logic        vld;
    logic [1:0]  a;
    logic [13:0] d;
    logic        exp_clk;
    logic        exp_act;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: scoreboard pops on launches, pushes accepted words, checks level.
  task automatic step();
    logic        acc, r;
    logic [15:0] w, exp;
    acc = in_valid && in_ready;
    w   = {addr_in, data_in};
    r   = rst;
    @(posedge clk); #1;
    if (r) begin
      q.delete();
      prev_clk  = 1'b0;
      prev_act  = 1'b0;
      last_word = '0;
    end else begin
      if (tx_active && !clk_out && (prev_clk || !prev_act)) begin
        if (q.size() > 0) begin
          exp = q.pop_front();
          npop++;
        end else begin
          exp = 16'h0000;
        end
        chk("launch_word", data_out, exp);
        last_word = exp;
      end else if (tx_active) begin
        chk("hold_word", data_out, last_word);
      end else begin
        chk("stopped_data", data_out, 0);
        chk("stopped_clk", clk_out, 0);
      end
      if (acc) q.push_back(w);
      chk("level", fifo_level, q.size());
      chk("in_ready", in_ready, q.size() != 16);
      prev_clk = clk_out;
      prev_act = tx_active;
    end
  endtask

  initial begin
    int nacc, p0;
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; addr_in = '0; data_in = '0;
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 14'h0000, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 14'h0000, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 2'd2, 14'h1234, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 2'd0, 14'h0000, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 2'd0, 14'h0000, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 2'd0, 14'h0000, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 2'd0, 14'h0000, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 2'd0, 14'h0000, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 2'd0, 14'h0000, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 2'd0, 14'h0000, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 2'd1, 14'h3abc, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 2'd0, 14'h0000, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 2'd0, 14'h0000, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 2'd0, 14'h0000, 1'b0, 1'b0};

    // Reset state
    step(); step();
    chk("rst_clk", clk_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_act", tx_active, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_level", fifo_level, 0);
    rst = 1'b0;

    // Clock shape, single word launch, idle word, stop after period
    for (int i = 0; i < 14; i++) begin
      enable = tbl[i].en; in_valid = tbl[i].vld; addr_in = tbl[i].a; data_in = tbl[i].d;
      step();
      chk($sformatf("tbl%0d_clk", i), clk_out, tbl[i].exp_clk);
      chk($sformatf("tbl%0d_act", i), tx_active, tbl[i].exp_act);
      if (i == 4) chk("word_9234", data_out, 16'h9234);
      if (i == 8) chk("idle_after", data_out, 16'h0000);
    end
    in_valid = 1'b0;
    chk("pending_kept", fifo_level, 1);

    rst = 1'b1; step(); rst = 1'b0;
    chk("rst2_level", fifo_level, 0);

    // Fill while stopped: 16 of 20 accepted
    nacc = 0;
    for (int i = 0; i < 20; i++) begin
      enable = 1'b0; in_valid = 1'b1;
      addr_in = 2'(i); data_in = 14'(i * 97 + 5);
      if (in_ready) nacc++;
      step();
    end
    chk("accepted", nacc, 16);
    chk("full_level", fifo_level, 16);
    chk("full_ready", in_ready, 0);

    // Enable with a push attempt while full and a concurrent pop
    p0 = npop;
    enable = 1'b1; in_valid = 1'b1; addr_in = 2'd3; data_in = 14'h3fff;
    step();
    chk("full_push_refused", fifo_level, 15);
    in_valid = 1'b0;
    repeat (68) step();
    chk("drained", fifo_level, 0);
    chk("words_out", npop - p0, 16);

    enable = 1'b0;
    repeat (6) step();
    chk("stopped_again", tx_active, 0);

    // Simultaneous push and pop at level 5
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; addr_in = 2'(i); data_in = 14'(14'h2000 + i);
      step();
    end
    chk("level5", fifo_level, 5);
    enable = 1'b1; in_valid = 1'b1; addr_in = 2'd1; data_in = 14'h0555;
    step();
    chk("pushpop_level", fifo_level, 5);
    in_valid = 1'b0;

    // Reset at phase 3 of the next period with 4 words buffered
    repeat (7) step();
    chk("pre_rst_level", fifo_level, 4);
    chk("pre_rst_phase3", clk_out, 1);
    rst = 1'b1; step();
    chk("midrst_clk", clk_out, 0);
    chk("midrst_data", data_out, 0);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_act", tx_active, 0);
    rst = 1'b0; enable = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule
